// File: rtl/ahb_slave_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer for one logic-module stack slot.
// Includes a default slave that answers unmapped accesses with a two-cycle ERROR.
module ahb_slave_decoder_mux #(
  parameter int                           NUM_SLAVES   = 3,
  parameter int                           ADDR_W       = 32,
  parameter int                           DATA_W       = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE     = {32'hC2100000, 32'h02000000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK     = {32'hFFF00000, 32'h0FF00000, 32'h0E000000},
  parameter bit                           STACK_DECODE = 1'b1,
  parameter int                           ERRCNT_W     = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic [3:0]                   HDRID,
  output logic [NUM_SLAVES-1:0]        HSEL,
  output logic                         HSELDefault,
  output logic                         HSELLOGICMODULE,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [2*NUM_SLAVES-1:0]      HRESP_S,
  input  logic [DATA_W*NUM_SLAVES-1:0] HRDATA_S,
  output logic                         HREADY_M,
  output logic [1:0]                   HRESP_M,
  output logic [DATA_W-1:0]            HRDATA_M,
  output logic [ERRCNT_W-1:0]          ErrCount,
  input  logic                         ErrClr
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  logic                  lm;
  logic                  stack_hit;
  logic [NUM_SLAVES-1:0] hit;
  logic [NUM_SLAVES-1:0] hsel_prio;
  logic                  any_hit;
  logic [NUM_SLAVES:0]   dsel_reg;
  state_t                state_reg, state_next;
  logic                  def_ready;
  logic [1:0]            def_resp;
  logic                  default_start;
  logic                  trans_active;
  logic [ERRCNT_W-1:0]   err_count_reg;

  // Stack position: each header ID owns one 256 MB window of the upper nibble.
  always_comb begin
    stack_hit = 1'b0;
    case ({HDRID, HADDR[31:28]})
      8'hEC, 8'h7D, 8'hBE, 8'hDF: stack_hit = 1'b1;
      default:                    stack_hit = 1'b0;
    endcase
  end

  generate
    if (STACK_DECODE) begin : g_stack
      assign lm = HRESETn & stack_hit;
    end else begin : g_nostack
      assign lm = HRESETn;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
      assign hit[gi] = (HADDR & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Lowest index wins when windows overlap.
  always_comb begin
    hsel_prio = '0;
    any_hit   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit[i] && !any_hit) begin
        hsel_prio[i] = 1'b1;
        any_hit      = 1'b1;
      end
    end
  end

  assign HSEL            = lm ? hsel_prio : '0;
  assign HSELDefault     = lm & ~any_hit;
  assign HSELLOGICMODULE = lm;

  assign trans_active  = (HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ);
  assign default_start = HREADY_M & HSELDefault & trans_active;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_reg <= '0;
    end else if (HREADY_M) begin
      dsel_reg <= {HSELDefault, HSEL};
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    def_ready  = 1'b1;
    def_resp   = RESP_OKAY;
    case (state_reg)
      ST_IDLE: begin
        if (default_start) state_next = ST_ERR1;
      end
      ST_ERR1: begin
        def_ready  = 1'b0;
        def_resp   = RESP_ERROR;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        def_resp   = RESP_ERROR;
        state_next = default_start ? ST_ERR1 : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // DSel is one-hot or zero, so at most one branch below applies.
  always_comb begin
    HREADY_M = 1'b1;
    HRESP_M  = RESP_OKAY;
    HRDATA_M = '0;
    if (dsel_reg[NUM_SLAVES]) begin
      HREADY_M = def_ready;
      HRESP_M  = def_resp;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_reg[i]) begin
        HREADY_M = HREADYOUT_S[i];
        HRESP_M  = HRESP_S[2*i +: 2];
        HRDATA_M = HRDATA_S[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_count_reg <= '0;
    end else if (ErrClr) begin
      err_count_reg <= '0;
    end else if (state_next == ST_ERR1 && err_count_reg != '1) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign ErrCount = err_count_reg;

endmodule
